// File: rtl/am2956_bus_sequencer.sv
// Round-robin sequencer sharing one tristate bus among N am2956 latch banks.
// Each transfer is LATCH (capture), HOLD drive cycles, then a break-before-make turnaround.
module am2956_bus_sequencer #(
  parameter int unsigned N    = 4,
  parameter int unsigned HOLD = 2,
  parameter int unsigned OWNW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  output logic [N-1:0]    gnt,
  output logic [N-1:0]    g,
  output logic [N-1:0]    oe_,
  output logic            busy,
  output logic [OWNW-1:0] owner
);

  localparam int unsigned CNTW = (HOLD > 1) ? $clog2(HOLD) : 1;

  typedef enum logic [1:0] {StIdle, StLatch, StDrive, StTurn} state_e;

  state_e          state_q, state_d;
  logic [OWNW-1:0] owner_q, owner_d;
  logic [OWNW-1:0] last_q,  last_d;
  logic [CNTW-1:0] cnt_q,   cnt_d;
  logic [N-1:0]    owner_oh;
  logic            any_req;

  // First requester strictly after 'from', wrapping, so the last owner has lowest priority.
  function automatic logic [OWNW-1:0] rr_pick(input logic [N-1:0] r, input logic [OWNW-1:0] from);
    logic [OWNW-1:0] win;
    logic [OWNW-1:0] sel;
    logic            found;
    int unsigned     idx;
    win   = from;
    found = 1'b0;
    for (int unsigned k = 1; k <= N; k++) begin
      idx = (32'(from) + k) % N;
      sel = OWNW'(idx);
      if (!found && r[sel]) begin
        win   = sel;
        found = 1'b1;
      end
    end
    return win;
  endfunction

  assign any_req  = |req;
  assign owner_oh = N'(1) << owner_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      owner_q <= '0;
      last_q  <= OWNW'(N - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (any_req) begin
          owner_d = rr_pick(req, last_q);
          state_d = StLatch;
        end
      end
      StLatch: begin
        cnt_d   = CNTW'(HOLD - 1);
        state_d = StDrive;
      end
      StDrive: begin
        // req is deliberately ignored here: a started transfer always runs its full length.
        if (cnt_q == '0) begin
          state_d = StTurn;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StTurn: begin
        last_d = owner_q;
        if (any_req) begin
          owner_d = rr_pick(req, owner_q);
          state_d = StLatch;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs depend on registered state only, so req never reaches the bus controls combinationally.
  always_comb begin
    g    = '0;
    oe_  = '1;
    busy = 1'b0;
    unique case (state_q)
      StIdle: ;
      StLatch: begin
        g    = owner_oh;
        busy = 1'b1;
      end
      StDrive: begin
        oe_  = ~owner_oh;
        busy = 1'b1;
      end
      StTurn: busy = 1'b1;
      default: ;
    endcase
  end

  assign gnt   = g;
  assign owner = owner_q;

endmodule

// File: tb/tb_am2956_bus_sequencer.sv
// Bench for am2956_bus_sequencer: transfer-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized request traffic.
module tb_am2956_bus_sequencer;

  localparam int N    = 4;
  localparam int HOLD = 2;
  localparam int OWNW = $clog2(N);

  logic            clk;
  logic            rst;
  logic [N-1:0]    req;
  logic [N-1:0]    gnt;
  logic [N-1:0]    g;
  logic [N-1:0]    oe_;
  logic            busy;
  logic [OWNW-1:0] owner;

  am2956_bus_sequencer #(.N(N), .HOLD(HOLD)) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .gnt  (gnt),
    .g    (g),
    .oe_  (oe_),
    .busy (busy),
    .owner(owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: a transfer is a position 0..HOLD+1 inside an active window.
  bit m_ok     = 1'b0;
  int m_active = 0;
  int m_pos    = 0;
  int m_owner  = 0;
  int m_last   = N - 1;

  function automatic int arb(input logic [N-1:0] r, input int from);
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (from + k) % N;
      if (((r >> i) & 1) != 0) return i;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_ok = 1'b1; m_active = 0; m_pos = 0; m_owner = 0; m_last = N - 1;
    end else if (m_ok) begin
      if (m_active == 0) begin
        if (req != 0) begin
          m_owner = arb(req, m_last); m_active = 1; m_pos = 0;
        end
      end else if (m_pos == HOLD + 1) begin
        m_last = m_owner;
        if (req != 0) begin
          m_owner = arb(req, m_last); m_pos = 0;
        end else begin
          m_active = 0;
        end
      end else begin
        m_pos++;
      end
    end
  end

  logic [N-1:0] prev_drv = '0;

  always @(negedge clk) begin
    logic [N-1:0] e_g, e_oe, drv;
    if (m_ok) begin
      e_g  = (m_active != 0 && m_pos == 0) ? N'(1 << m_owner) : '0;
      e_oe = (m_active != 0 && m_pos >= 1 && m_pos <= HOLD) ? ~N'(1 << m_owner) : '1;
      chk("m_g", g, e_g);
      chk("m_gnt", gnt, e_g);
      chk("m_oe", oe_, e_oe);
      chk("m_busy", busy, m_active != 0);
      chk("m_owner", owner, 32'(m_owner));
      drv = ~oe_;
      chk("inv_one_oe", $countones(drv) <= 1, 1);
      chk("inv_g_oe_excl", (g != 0) && (drv != 0), 0);
      chk("inv_gnt_eq_g", gnt, g);
      chk("inv_bbm", (prev_drv != 0) && (drv != 0) && (drv != prev_drv), 0);
      prev_drv = drv;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int glog[$];
  int gcyc[$];

  task automatic run_log(input int n);
    repeat (n) begin
      tick();
      if (gnt != 0) begin
        glog.push_back(int'(owner));
        gcyc.push_back(cyc);
      end
    end
  endtask

  task automatic do_reset(input logic [N-1:0] r);
    rst = 1'b1; req = r;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int exp_full [5] = '{0, 1, 2, 3, 0};
    int exp_skip [3] = '{3, 0, 2};
    int mode;
    rst = 1'b1;
    req = '1;

    // Reset held for two edges with all requests high.
    repeat (2) begin
      tick();
      chk("rst_g", g, 4'b0000);
      chk("rst_oe", oe_, 4'b1111);
      chk("rst_gnt", gnt, 4'b0000);
      chk("rst_busy", busy, 0);
      chk("rst_owner", owner, 0);
    end

    // Single one-edge request from IDLE.
    rst = 1'b0; req = 4'b0100;
    tick();
    req = '0;
    chk("single_g", g, 4'b0100);
    chk("single_gnt", gnt, 4'b0100);
    chk("single_oe_latch", oe_, 4'b1111);
    tick();
    chk("single_oe_d1", oe_, 4'b1011);
    chk("single_g_d1", g, 4'b0000);
    tick();
    chk("single_oe_d2", oe_, 4'b1011);
    tick();
    chk("single_oe_turn", oe_, 4'b1111);
    chk("single_busy_turn", busy, 1);
    tick();
    chk("single_busy_idle", busy, 0);

    // Owner 2 just completed; requester 1 stays low and must be skipped.
    req = 4'b1101;
    glog.delete(); gcyc.delete();
    run_log(12);
    req = '0;
    chk("skip_count", glog.size(), 3);
    for (int i = 0; i < 3 && i < glog.size(); i++) chk("skip_order", glog[i], exp_skip[i]);

    // Full contention from reset release.
    do_reset('1);
    req = '1;
    glog.delete(); gcyc.delete();
    run_log(20);
    chk("full_count", glog.size(), 5);
    for (int i = 0; i < 5 && i < glog.size(); i++) chk("full_order", glog[i], exp_full[i]);
    for (int i = 1; i < gcyc.size(); i++) chk("full_spacing", gcyc[i] - gcyc[i-1], HOLD + 2);

    // Request withdrawn during the first drive cycle still completes.
    do_reset('0);
    req = 4'b0010;
    tick();
    chk("wd_g", g, 4'b0010);
    tick();
    req = '0;
    chk("wd_oe_d1", oe_, 4'b1101);
    tick();
    chk("wd_oe_d2", oe_, 4'b1101);
    tick();
    chk("wd_oe_turn", oe_, 4'b1111);
    chk("wd_busy_turn", busy, 1);
    tick();
    chk("wd_busy_idle", busy, 0);

    // Reset while requester 3 drives the bus.
    do_reset('0);
    req = 4'b1000;
    tick();
    req = '0;
    tick();
    chk("mid_oe_drive", oe_, 4'b0111);
    rst = 1'b1; req = '1;
    tick();
    chk("mid_oe_rst", oe_, 4'b1111);
    chk("mid_g_rst", g, 4'b0000);
    chk("mid_busy_rst", busy, 0);
    rst = 1'b0;
    tick();
    chk("mid_gnt_after", gnt, 4'b0001);
    chk("mid_owner_after", owner, 0);

    // Randomized traffic with varying request density and occasional resets.
    mode = 0;
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) mode = int'($urandom_range(0, 3));
      unique case (mode)
        0: req = N'($urandom);
        1: req = N'($urandom) & N'($urandom) & N'($urandom);
        2: if ($urandom_range(0, 7) == 0) req = N'($urandom);
        default: req = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      endcase
      rst = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 1'b0; req = '0;
    repeat (HOLD + 4) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
